swallow_ctrl: RTL and testbench
===============================

SWALLOW_CTRL -- requirements
Module: swallow_ctrl

Interface
REQ-001 SHALL declare parameter P_W, default 8: width of the prescaler-cycle count P.
REQ-002 SHALL declare parameter F_W, default 12: width of the fractional word and accumulator.
REQ-003 SHALL have port clk, input, 1: the 8/9 prescaler output clock, one rising edge per prescaler cycle.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1: run request.
REQ-006 SHALL have port cfg_we, input, 1: one-cycle write strobe for p_in, s_in, frac_in.
REQ-007 SHALL have port p_in, input, P_W: prescaler cycles per output period.
REQ-008 SHALL have port s_in, input, 3: integer swallow count S (0..7).
REQ-009 SHALL have port frac_in, input, F_W: fractional word.
REQ-010 SHALL have port MC, output, 1: modulus control to the prescaler (1 = divide by 9, 0 = divide by 8).
REQ-011 SHALL have port div_out, output, 1: one-clk pulse on the last prescaler cycle of each output period.
REQ-012 SHALL have port busy, output, 1: high while in RUN.
REQ-013 SHALL have port err, output, 1: sticky configuration-clamp flag, cleared only by reset.

Function
REQ-014 SHALL hold shadow registers for P, S and F; cfg_we loads them in the same cycle, in any state.
REQ-015 SHALL hold active registers copied from the shadows only at period start, so a mid-period write never disturbs the current period.
REQ-016 SHALL implement a two-state FSM: IDLE, RUN.
REQ-017 IDLE -> RUN: enable sampled high; the next clk is cycle 0 of the first period.
REQ-018 RUN -> IDLE: enable sampled low on the last cycle of a period; a period once started always completes.
REQ-019 At each period start, acc_next = acc + F (F_W-bit wrap); carry = overflow bit; S_eff = S + carry (0..8).
REQ-020 SHALL load pcnt = P_eff-1 and scnt = S_eff at period start; pcnt decrements every clk; scnt decrements while nonzero.
REQ-021 MC SHALL be registered and high for exactly the first S_eff cycles of the period, low for the remaining P_eff-S_eff cycles.
REQ-022 Each period SHALL span P_eff prescaler cycles, giving 8*P_eff + S_eff input cycles.
REQ-023 div_out SHALL be high exactly on the cycle where pcnt == 0, low otherwise.
REQ-024 Back-to-back periods SHALL have no gap; the cycle after the div_out cycle is cycle 0 of the next period.
REQ-025 P_eff SHALL be max(P, 2); if P < 2, SHALL set err.
REQ-026 If S_eff > P_eff, S_eff SHALL be clamped to P_eff and err set.
REQ-027 In IDLE, MC SHALL be 0, div_out 0, and acc SHALL retain its value.
REQ-028 If enable and cfg_we are both active on the entry cycle, the entry period SHALL use the newly written values.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, MC=0, div_out=0, busy=0, err=0, acc=0, pcnt=0, scnt=0, shadows and actives=0.
REQ-030 Reset asserted mid-period SHALL abort the period with no further div_out; after release, operation restarts only via REQ-017.

Verification
REQ-031 Bench SHALL run: P=10, S=3, F=0, enable=1 -> div_out every 10 clk; MC high for 3 clk, then low for 7; err=0.
REQ-032 Bench SHALL run: P=10, S=3, F=2048 (F_W=12) -> S_eff alternates 3,4,3,4...; periods alternate 83 and 84 input cycles.
REQ-033 Bench SHALL run: P=5, S=7, F=4095 -> S_eff clamped to 5; MC high for all 5 cycles; err=1 and stays 1.
REQ-034 Bench SHALL run: cfg_we with P=12 on cycle 4 of a P=10 period -> current period stays 10 clk; next period is 12 clk.
REQ-035 Bench SHALL run: enable dropped on cycle 2 of a period -> period completes with div_out; busy=0 on the following clk; MC=0.
REQ-036 Bench SHALL run: rst_n pulsed low on cycle 5 -> all outputs 0 asynchronously; no div_out until enable re-sampled high.

Source files
------------

// File: rtl/swallow_ctrl.sv
// Pulse-swallow controller for an 8/9 dual-modulus prescaler: each output period spans
// P_eff prescaler cycles, S_eff of them at divide-by-9, with a fractional accumulator dithering S.
module swallow_ctrl #(
    parameter int P_W = 8,
    parameter int F_W = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic           cfg_we,
    input  logic [P_W-1:0] p_in,
    input  logic [2:0]     s_in,
    input  logic [F_W-1:0] frac_in,
    output logic           MC,
    output logic           div_out,
    output logic           busy,
    output logic           err
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state, state_n;
    logic [P_W-1:0] p_sh, p_act, p_act_n;
    logic [2:0]     s_sh;
    logic [3:0]     s_act, s_act_n;
    logic [F_W-1:0] f_sh;
    logic [F_W-1:0] acc, acc_n;
    logic [P_W-1:0] pcnt, pcnt_n;
    logic [3:0]     scnt, scnt_n;
    logic           mc_q, mc_n;
    logic           div_q, div_n;
    logic           err_q, err_n;

    logic [P_W-1:0] p_src, p_eff, p_act_eff;
    logic [2:0]     s_src;
    logic [F_W-1:0] f_src;
    logic [F_W:0]   sum;
    logic           carry;
    logic [3:0]     s_raw, s_eff;
    logic           start, act_bad;

    // A write on the period-start edge is seen by that period, so sources bypass the shadows.
    always_comb begin
        p_src     = cfg_we ? p_in : p_sh;
        s_src     = cfg_we ? s_in : s_sh;
        f_src     = cfg_we ? frac_in : f_sh;
        sum       = {1'b0, acc} + {1'b0, f_src};
        carry     = sum[F_W];
        s_raw     = {1'b0, s_src} + {3'b000, carry};
        p_eff     = (p_src < P_W'(2)) ? P_W'(2) : p_src;
        s_eff     = (P_W'(s_raw) > p_eff) ? p_eff[3:0] : s_raw;
        p_act_eff = (p_act < P_W'(2)) ? P_W'(2) : p_act;
        act_bad   = (p_act < P_W'(2)) || (P_W'(s_act) > p_act_eff);
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        pcnt_n  = pcnt;
        scnt_n  = scnt;
        mc_n    = 1'b0;
        div_n   = 1'b0;
        p_act_n = p_act;
        s_act_n = s_act;
        start   = 1'b0;
        err_n   = err_q | ((state == RUN) && act_bad);

        case (state)
            IDLE: begin
                if (enable) start = 1'b1;
            end
            RUN: begin
                if (pcnt == '0) begin
                    if (enable) begin
                        start = 1'b1;
                    end else begin
                        state_n = IDLE;
                        scnt_n  = '0;
                    end
                end else begin
                    pcnt_n = pcnt - P_W'(1);
                    scnt_n = (scnt != 4'd0) ? scnt - 4'd1 : 4'd0;
                    mc_n   = (scnt_n != 4'd0);
                    div_n  = (pcnt_n == '0);
                end
            end
            default: state_n = IDLE;
        endcase

        if (start) begin
            state_n = RUN;
            acc_n   = sum[F_W-1:0];
            pcnt_n  = p_eff - P_W'(1);
            scnt_n  = s_eff;
            mc_n    = (s_eff != 4'd0);
            div_n   = 1'b0;
            p_act_n = p_src;
            s_act_n = s_raw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            p_sh  <= '0;
            s_sh  <= '0;
            f_sh  <= '0;
            p_act <= '0;
            s_act <= '0;
            acc   <= '0;
            pcnt  <= '0;
            scnt  <= '0;
            mc_q  <= 1'b0;
            div_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            if (cfg_we) begin
                p_sh <= p_in;
                s_sh <= s_in;
                f_sh <= frac_in;
            end
            p_act <= p_act_n;
            s_act <= s_act_n;
            acc   <= acc_n;
            pcnt  <= pcnt_n;
            scnt  <= scnt_n;
            mc_q  <= mc_n;
            div_q <= div_n;
            err_q <= err_n;
        end
    end

    assign MC      = mc_q;
    assign div_out = div_q;
    assign busy    = (state == RUN);
    assign err     = err_q;

endmodule

// File: tb/tb_swallow_ctrl.sv
// Directed bench for swallow_ctrl: a table of configurations measured over two periods,
// plus hand sequences for mid-period writes, enable drop and asynchronous reset.
module tb_swallow_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        cfg_we;
    logic [7:0]  p_in;
    logic [2:0]  s_in;
    logic [11:0] frac_in;
    logic        MC;
    logic        div_out;
    logic        busy;
    logic        err;

    int tests;
    int failures;

    typedef struct {
        logic [7:0]  p;
        logic [2:0]  s;
        logic [11:0] f;
        int          len;
        int          mc0;
        int          mc1;
        int          in0;
        int          in1;
        int          err;
    } vec_t;

    vec_t vecs[7];

    swallow_ctrl #(.P_W(8), .F_W(12)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .cfg_we  (cfg_we),
        .p_in    (p_in),
        .s_in    (s_in),
        .frac_in (frac_in),
        .MC      (MC),
        .div_out (div_out),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic resetDut();
        rst_n  = 1'b0;
        enable = 1'b0;
        cfg_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] p, input logic [2:0] s, input logic [11:0] f);
        p_in    = p;
        s_in    = s;
        frac_in = f;
        cfg_we  = 1'b1;
        enable  = 1'b1;
    endtask

    // Samples one period cycle per negedge until div_out; optional mid-period write or enable drop.
    task automatic measurePeriod(input int wr_at, input logic [7:0] wr_p, input int drop_at,
                                 output int len, output int mcc);
        bit done;
        len  = 0;
        mcc  = 0;
        done = 1'b0;
        while (!done && len < 200) begin
            @(negedge clk);
            cfg_we = 1'b0;
            if (MC) mcc++;
            if (len == wr_at) begin
                p_in   = wr_p;
                cfg_we = 1'b1;
            end
            if (len == drop_at) enable = 1'b0;
            if (div_out) done = 1'b1;
            len++;
        end
    endtask

    initial begin
        int len0, len1, mc0, mc1, cnt_div, cnt_busy;
        tests    = 0;
        failures = 0;
        rst_n    = 1'b1;
        enable   = 1'b0;
        cfg_we   = 1'b0;
        p_in     = '0;
        s_in     = '0;
        frac_in  = '0;

        vecs[0] = '{8'd10, 3'd0 + 3'd3, 12'd0,    10, 3, 3, 83, 83, 0};
        vecs[1] = '{8'd10, 3'd3,        12'd2048, 10, 3, 4, 83, 84, 0};
        vecs[2] = '{8'd5,  3'd7,        12'd4095, 5,  5, 5, 45, 45, 1};
        vecs[3] = '{8'd1,  3'd0,        12'd0,    2,  0, 0, 16, 16, 1};
        vecs[4] = '{8'd4,  3'd2,        12'd1024, 4,  2, 2, 34, 34, 0};
        vecs[5] = '{8'd8,  3'd7,        12'd4095, 8,  7, 8, 71, 72, 0};
        vecs[6] = '{8'd2,  3'd0,        12'd2048, 2,  0, 1, 16, 17, 0};

        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset MC", int'(MC), 0);
        checkOutput("reset div_out", int'(div_out), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset err", int'(err), 0);

        for (int i = 0; i < 7; i++) begin
            resetDut();
            applyStimulus(vecs[i].p, vecs[i].s, vecs[i].f);
            measurePeriod(-1, 8'd0, -1, len0, mc0);
            measurePeriod(-1, 8'd0, -1, len1, mc1);
            checkOutput($sformatf("v%0d len0", i), len0, vecs[i].len);
            checkOutput($sformatf("v%0d len1", i), len1, vecs[i].len);
            checkOutput($sformatf("v%0d mc0", i), mc0, vecs[i].mc0);
            checkOutput($sformatf("v%0d mc1", i), mc1, vecs[i].mc1);
            checkOutput($sformatf("v%0d in0", i), 8 * len0 + mc0, vecs[i].in0);
            checkOutput($sformatf("v%0d in1", i), 8 * len1 + mc1, vecs[i].in1);
            checkOutput($sformatf("v%0d busy", i), int'(busy), 1);
            checkOutput($sformatf("v%0d err", i), int'(err), vecs[i].err);
        end

        // Mid-period P write only takes effect at the next period start.
        resetDut();
        applyStimulus(8'd10, 3'd3, 12'd0);
        measurePeriod(4, 8'd12, -1, len0, mc0);
        measurePeriod(-1, 8'd0, -1, len1, mc1);
        checkOutput("midwrite len0", len0, 10);
        checkOutput("midwrite len1", len1, 12);
        checkOutput("midwrite mc1", mc1, 3);

        // Enable dropped on cycle 2: the period still finishes, then the block idles.
        resetDut();
        applyStimulus(8'd10, 3'd3, 12'd0);
        measurePeriod(-1, 8'd0, 2, len0, mc0);
        checkOutput("drop len", len0, 10);
        checkOutput("drop mc", mc0, 3);
        @(negedge clk);
        checkOutput("drop busy after", int'(busy), 0);
        checkOutput("drop MC after", int'(MC), 0);
        cnt_div = 0;
        repeat (20) begin
            @(negedge clk);
            if (div_out) cnt_div++;
        end
        checkOutput("drop no div", cnt_div, 0);

        // Asynchronous reset on cycle 5 of a period with MC still high.
        resetDut();
        applyStimulus(8'd10, 3'd6, 12'd0);
        @(negedge clk);
        cfg_we = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("pre-reset MC", int'(MC), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("async MC", int'(MC), 0);
        checkOutput("async div_out", int'(div_out), 0);
        checkOutput("async busy", int'(busy), 0);
        checkOutput("async err", int'(err), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b0;
        cnt_div  = 0;
        cnt_busy = 0;
        repeat (30) begin
            @(negedge clk);
            if (div_out) cnt_div++;
            if (busy) cnt_busy++;
        end
        checkOutput("post-reset no div", cnt_div, 0);
        checkOutput("post-reset no busy", cnt_busy, 0);
        applyStimulus(8'd10, 3'd3, 12'd0);
        measurePeriod(-1, 8'd0, -1, len0, mc0);
        checkOutput("restart len", len0, 10);
        checkOutput("restart mc", mc0, 3);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
